note_mixer: RTL and testbench
=============================

# note_mixer

Polyphonic square-wave tone generator sitting directly downstream of the keyboard note-enable logic and upstream of the audio codec serializer. It takes the 13-bit held-note vector (C4 through C5), advances one phase accumulator per note once per audio frame, and sums the enabled voices into one signed 16-bit sample. Voices are processed serially, one per clock, over a shared adder. The result is delivered to the codec interface with a request/valid handshake.

## Interface
- NUM_NOTES, 13, voice count; bit 0 = C4 … bit 12 = C5
- ACC_W, 24, phase accumulator width
- AMPLITUDE, 16'sd2000, per-voice square-wave magnitude
- CLK_50MHz  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high; one clock, reset asynchronous active-high
- note_en  input  13  held-note vector from the keyboard decoder; level, synchronous to CLK_50MHz
- sample_req  input  1  one-cycle pulse per 48 kHz codec frame
- sample_out  output  16  signed mixed sample; held until the next sample_valid
- sample_valid  output  1  one-cycle pulse when sample_out updates
- busy  output  1  high while a frame is being computed

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: on sample_req, snapshot note_en into en_snap, clear the 20-bit signed sum, set voice index v=0, go to ACCUM.
- ACCUM: one voice per cycle.
  - If en_snap[v] is set, the contribution is +AMPLITUDE when phase[v][ACC_W-1]=0 and −AMPLITUDE otherwise. The contribution uses the phase before the increment. The phase is then updated as phase[v] += PHASE_INC[v], mod 2^ACC_W.
  - If en_snap[v] is clear, the contribution is 0 and phase[v] is forced to 0, so every note attacks at a positive half-cycle.
  - After the last voice, go to DONE.
- DONE: saturate the sum to [−32768, 32767], register it to sample_out, pulse sample_valid, return to IDLE.
- PHASE_INC[v] = round(f_v·2^24/48000). C4=91446 … A4=153791 … C5=182892.
- sample_req while busy: ignored and dropped, with no queuing.
- note_en changes during a frame have no effect until the next sample_req.

## Timing
- Reset values: sample_out=0, sample_valid=0, busy=0, all phases=0, state=IDLE.
- sample_req sampled at edge k. busy is high from edge k. ACCUM covers edges k+1…k+N, where N is the active voice count. DONE is at edge k+N+1.
- sample_valid is high for exactly one cycle after edge k+N+1, and busy falls at the same edge.
- Latency from req to valid is 14 clocks with 13 voices and 13 clocks with 12 voices.
- Frame spacing is about 1042 clocks, so the mixer is never busy at a legitimate request.
- Reset asserted mid-frame: immediate return to IDLE, phases zeroed, and no sample_valid for the aborted frame.

## Configuration
- NOTE_MIXER_C5_EN defined: 13 voices and 13 ACCUM cycles; note_en[12] plays C5.
- NOTE_MIXER_C5_EN undefined: 12 voices, 12 ACCUM cycles, and 13-clock latency. note_en[12] is ignored and phase[12] stays 0.

## Structure
- Package note_mixer_pkg holds NUM_NOTES, ACC_W, AMPLITUDE, the PHASE_INC constant table (13 × 24-bit), and the state enumeration.
- Sub-module note_phase_regs is a 13 × ACC_W register file. It has one combinational read port and one synchronous write port, both indexed by v. It supports a clear-all on reset.
- The FSM, adder and saturation stay in note_mixer.

## Test plan
- Reset, then idle for 100 clocks: sample_out=0, sample_valid=0, busy=0 throughout.
- note_en=0, then sample_req at edge k: busy high k…k+14. sample_valid pulses once after edge k+14 with sample_out=0.
- note_en=13'h200 (A4 only), 60 requests spaced 1042 clocks:
  - Requests 1–55 give +2000.
  - Request 56 gives −2000, because phase 55·153791 ≥ 2^23.
- note_en=13'h1FFF on the first frame after reset:
  - With the macro: sample_out=26000.
  - Without the macro: 24000 and latency 13.
- sample_req at k, second sample_req at k+5: exactly one sample_valid. The phase of an enabled voice has advanced only once.
- Frame in progress, reset pulsed at k+7: busy=0 immediately and no sample_valid. The next frame with A4 enabled gives +2000 from phase 0.

Source files
------------

// File: rtl/note_mixer_pkg.sv
// Shared constants, state encoding and helpers for the note_mixer tone generator.
// NOTE_MIXER_C5_EN selects 13 voices (C4..C5); otherwise C5 is left out and 12 voices play.
package note_mixer_pkg;

  localparam int NUM_NOTES = 13;
  localparam int ACC_W     = 24;
  localparam int SUM_W     = 20;
  localparam int IDX_W     = 4;

  localparam logic signed [15:0]      AMPLITUDE = 16'sd2000;
  localparam logic signed [SUM_W-1:0] AMP_SUM   = 20'sd2000;
  localparam logic signed [SUM_W-1:0] SAT_MAX   = 20'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN   = -20'sd32768;

`ifdef NOTE_MIXER_C5_EN
  localparam int ACTIVE_NOTES = 13;
`else
  localparam int ACTIVE_NOTES = 12;
`endif

  localparam logic [IDX_W-1:0] LAST_VOICE    = IDX_W'(ACTIVE_NOTES - 1);
  localparam logic [IDX_W-1:0] NUM_NOTES_IDX = IDX_W'(NUM_NOTES);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  // Per-note phase step for a 48 kHz frame rate, index 0 = C4 .. 12 = C5.
  function automatic logic [ACC_W-1:0] phaseInc(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return 24'd91446;
      4'd1:    return 24'd96882;
      4'd2:    return 24'd102643;
      4'd3:    return 24'd108747;
      4'd4:    return 24'd115213;
      4'd5:    return 24'd122064;
      4'd6:    return 24'd129322;
      4'd7:    return 24'd137012;
      4'd8:    return 24'd145160;
      4'd9:    return 24'd153791;
      4'd10:   return 24'd162936;
      4'd11:   return 24'd172625;
      4'd12:   return 24'd182892;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [15:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX)
      return 16'sh7FFF;
    else if (s < SAT_MIN)
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

endpackage

// File: rtl/note_phase_regs.sv
// Phase accumulator register file: one combinational read and one synchronous
// write port sharing the voice index, cleared as a whole on reset.
module note_phase_regs
  import note_mixer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             we_i,
  input  logic [ACC_W-1:0] wdata_i,
  output logic [ACC_W-1:0] rdata_o
);

  logic [ACC_W-1:0] mem_q [NUM_NOTES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_NOTES; i++) mem_q[i] <= '0;
    end else if (we_i && (idx_i < NUM_NOTES_IDX)) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = (idx_i < NUM_NOTES_IDX) ? mem_q[idx_i] : '0;

endmodule

// File: rtl/note_mixer.sv
// Serial polyphonic square-wave mixer: one voice per clock over a shared adder.
// Define NOTE_MIXER_C5_EN to include C5 (note_en[12]) as a 13th voice.
module note_mixer
  import note_mixer_pkg::*;
(
  input  logic                 CLK_50MHz,
  input  logic                 reset,
  input  logic [NUM_NOTES-1:0] note_en,
  input  logic                 sample_req,
  output logic signed [15:0]   sample_out,
  output logic                 sample_valid,
  output logic                 busy
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        v_q, v_d;
  logic [NUM_NOTES-1:0]    enSnap_q, enSnap_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [15:0]      sampleOut_q, sampleOut_d;
  logic                    sampleValid_q, sampleValid_d;
  logic                    phaseWe;
  logic [ACC_W-1:0]        phaseRd, phaseWr;

  note_phase_regs uPhase (
    .clk_i   (CLK_50MHz),
    .rst_i   (reset),
    .idx_i   (v_q),
    .we_i    (phaseWe),
    .wdata_i (phaseWr),
    .rdata_o (phaseRd)
  );

  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      v_q           <= '0;
      enSnap_q      <= '0;
      sum_q         <= '0;
      sampleOut_q   <= '0;
      sampleValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      enSnap_q      <= enSnap_d;
      sum_q         <= sum_d;
      sampleOut_q   <= sampleOut_d;
      sampleValid_q <= sampleValid_d;
    end
  end

  // Requests arriving outside IDLE are simply not looked at, so they drop.
  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    enSnap_d      = enSnap_q;
    sum_d         = sum_q;
    sampleOut_d   = sampleOut_q;
    sampleValid_d = 1'b0;
    phaseWe       = 1'b0;
    phaseWr       = '0;
    case (state_q)
      IDLE: begin
        if (sample_req) begin
          enSnap_d = note_en;
          sum_d    = '0;
          v_d      = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        phaseWe = 1'b1;
        if (enSnap_q[v_q]) begin
          phaseWr = phaseRd + phaseInc(v_q);
          sum_d   = sum_q + (phaseRd[ACC_W-1] ? -AMP_SUM : AMP_SUM);
        end
        if (v_q == LAST_VOICE) begin
          state_d = DONE;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      DONE: begin
        sampleOut_d   = saturate(sum_q);
        sampleValid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample_out   = sampleOut_q;
  assign sample_valid = sampleValid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_note_mixer.sv
// Self-checking bench for note_mixer: vector table plus scoreboard queue of
// expected samples, with hand-written sequences for dropped requests and aborts.
module tb_note_mixer;

`ifdef NOTE_MIXER_C5_EN
  localparam int LATENCY = 14;
  localparam logic signed [15:0] ALL_ON = 16'sd26000;
  localparam logic signed [15:0] C5_ONLY = 16'sd2000;
`else
  localparam int LATENCY = 13;
  localparam logic signed [15:0] ALL_ON = 16'sd24000;
  localparam logic signed [15:0] C5_ONLY = 16'sd0;
`endif
  localparam logic [23:0] A4_INC = 24'd153791;

  logic               CLK_50MHz = 1'b0;
  logic               reset;
  logic [12:0]        note_en;
  logic               sample_req;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               busy;

  int                 checks = 0;
  int                 failures = 0;
  int                 validCount = 0;
  int                 validBefore;
  logic signed [15:0] expQ [$];
  logic signed [15:0] monExp;
  logic signed [15:0] frameExp;
  logic [23:0]        modelPhase;

  typedef struct {
    logic [12:0]        en;
    logic signed [15:0] expSample;
  } vec_t;
  vec_t vecs [6];

  note_mixer dut (
    .CLK_50MHz    (CLK_50MHz),
    .reset        (reset),
    .note_en      (note_en),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #10 CLK_50MHz = ~CLK_50MHz;

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge CLK_50MHz) begin
    if (sample_valid === 1'b1) begin
      validCount++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid actual=%0d expected=none", sample_out);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sample_out", sample_out, monExp);
      end
    end
  end

  task automatic pulseReset();
    @(negedge CLK_50MHz);
    reset = 1'b1;
    @(negedge CLK_50MHz);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [12:0] en, input logic signed [15:0] expSample,
                               input bit expectValid);
    @(negedge CLK_50MHz);
    note_en    = en;
    sample_req = 1'b1;
    if (expectValid) expQ.push_back(expSample);
    @(negedge CLK_50MHz);
    sample_req = 1'b0;
  endtask

  // Called right after applyStimulus; counts clocks from the request edge to valid.
  task automatic waitValid(input string name, input int expLatency);
    int n;
    n = 0;
    checkOutput({name, "_busy_start"}, busy, 1);
    while (sample_valid !== 1'b1 && n < 60) begin
      @(negedge CLK_50MHz);
      n++;
      if (sample_valid !== 1'b1) checkOutput({name, "_busy_hold"}, busy, 1);
    end
    checkOutput({name, "_latency"}, n, expLatency);
    checkOutput({name, "_busy_end"}, busy, 0);
    @(negedge CLK_50MHz);
    checkOutput({name, "_valid_drop"}, sample_valid, 0);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{en: 13'h0000, expSample: 16'sd0};
    vecs[1] = '{en: 13'h0200, expSample: 16'sd2000};
    vecs[2] = '{en: 13'h1FFF, expSample: ALL_ON};
    vecs[3] = '{en: 13'h1000, expSample: C5_ONLY};
    vecs[4] = '{en: 13'h0FFF, expSample: 16'sd24000};
    vecs[5] = '{en: 13'h0421, expSample: 16'sd6000};

    reset      = 1'b1;
    note_en    = '0;
    sample_req = 1'b0;
    repeat (3) @(negedge CLK_50MHz);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_50MHz);
      checkOutput("idle_out", sample_out, 0);
      checkOutput("idle_valid", sample_valid, 0);
      checkOutput("idle_busy", busy, 0);
    end

    applyStimulus(13'h0000, 16'sd0, 1'b1);
    note_en = 13'h1FFF;
    waitValid("silent_frame", LATENCY);

    // Each vector starts from zeroed phases; note_en is flipped mid-frame.
    for (int i = 0; i < 6; i++) begin
      pulseReset();
      checkOutput("reset_out", sample_out, 0);
      applyStimulus(vecs[i].en, vecs[i].expSample, 1'b1);
      note_en = ~vecs[i].en;
      waitValid("vec", LATENCY);
    end

    // A4 alone: sign flips once 55 increments pass half of the phase range.
    pulseReset();
    modelPhase = '0;
    for (int r = 1; r <= 60; r++) begin
      frameExp   = modelPhase[23] ? -16'sd2000 : 16'sd2000;
      modelPhase = modelPhase + A4_INC;
      applyStimulus(13'h0200, frameExp, 1'b1);
      repeat (1040) @(negedge CLK_50MHz);
    end

    // Second request while busy must be dropped without touching phases.
    pulseReset();
    validBefore = validCount;
    applyStimulus(13'h0200, 16'sd2000, 1'b1);
    repeat (4) @(negedge CLK_50MHz);
    sample_req = 1'b1;
    @(negedge CLK_50MHz);
    sample_req = 1'b0;
    repeat (30) @(negedge CLK_50MHz);
    checkOutput("double_req_valids", validCount - validBefore, 1);
    modelPhase = A4_INC;
    for (int r = 2; r <= 56; r++) begin
      frameExp   = modelPhase[23] ? -16'sd2000 : 16'sd2000;
      modelPhase = modelPhase + A4_INC;
      applyStimulus(13'h0200, frameExp, 1'b1);
      repeat (20) @(negedge CLK_50MHz);
    end

    // Reset seven edges into a frame aborts it silently.
    applyStimulus(13'h0200, 16'sd0, 1'b0);
    repeat (6) @(negedge CLK_50MHz);
    @(posedge CLK_50MHz);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", sample_valid, 0);
    validBefore = validCount;
    @(negedge CLK_50MHz);
    reset = 1'b0;
    repeat (30) @(negedge CLK_50MHz);
    checkOutput("abort_no_valid", validCount - validBefore, 0);
    applyStimulus(13'h0200, 16'sd2000, 1'b1);
    waitValid("after_abort", LATENCY);

    repeat (5) @(negedge CLK_50MHz);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
